// File: rtl/pio_ext_pkg.sv
// Shared constants for the extended Avalon-MM PIO: register addresses and
// edge-capture selection codes.
package pio_ext_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_DIRECTION = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain followed by a history flop. Produces the
// synchronised pin value and a one-cycle pulse per bit on the selected edge.
module pio_sync_edge
    import pio_ext_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edge_pulse_o
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  rise;
    logic [WIDTH-1:0]                  fall;

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value, so the chain shifts by exactly one stage per clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync_o = sync_q[SYNC_STAGES-1];
    assign rise      = in_sync_o & ~prev_q;
    assign fall      = ~in_sync_o & prev_q;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_pulse_o = fall;
            EDGE_ANY:  edge_pulse_o = rise | fall;
            default:   edge_pulse_o = rise;
        endcase
    end

endmodule

// File: rtl/avalon_pio_ext.sv
// Avalon-MM slave PIO with per-bit direction, set/clear writes, synchronised
// inputs, edge capture and a maskable level interrupt.
module avalon_pio_ext
    import pio_ext_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               EDGE_TYPE   = EDGE_RISE,
    parameter int               SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wd;
    logic             wr_en;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_port_i    (in_port),
        .in_sync_o    (in_sync),
        .edge_pulse_o (edge_pulse)
    );

    assign wr_en = chipselect & ~write_n;
    assign wd    = writedata[WIDTH-1:0];

    if (WIDTH < 32) begin : g_unused_wd
        logic unused_wd;
        assign unused_wd = ^writedata[31:WIDTH];
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        mask_d  = mask_q;
        cap_clr = '0;
        if (wr_en) begin
            case (address)
                ADDR_DATA:      data_d  = wd;
                ADDR_DIRECTION: dir_d   = wd;
                ADDR_IRQ_MASK:  mask_d  = wd;
                ADDR_EDGE_CAP:  cap_clr = wd;
                ADDR_OUTSET:    data_d  = data_q | wd;
                ADDR_OUTCLEAR:  data_d  = data_q & ~wd;
                default:        ;
            endcase
        end
        // A fresh edge on an input bit overrides a simultaneous clear.
        cap_d = (cap_q & ~cap_clr) | (edge_pulse & ~dir_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            dir_q  <= '0;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0] = (dir_q & data_q) | (~dir_q & in_sync);
            ADDR_DIRECTION: readdata[WIDTH-1:0] = dir_q;
            ADDR_IRQ_MASK:  readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP:  readdata[WIDTH-1:0] = cap_q;
            default:        ;
        endcase
    end

    assign out_port = data_q;
    assign oe       = dir_q;
    assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_avalon_pio_ext.sv
// Directed bench for avalon_pio_ext: a rising-edge instance and an any-edge
// instance share one bus and one set of pins.
module tb_avalon_pio_ext;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;

    logic [31:0] readdata,   readdata_a;
    logic [7:0]  out_port,   out_port_a;
    logic [7:0]  oe,         oe_a;
    logic        irq,        irq_a;

    int n_asserts = 0;
    int n_fail    = 0;

    avalon_pio_ext #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .out_port(out_port), .oe(oe), .irq(irq)
    );

    avalon_pio_ext #(
        .WIDTH(8), .RESET_VALUE(8'hA5), .EDGE_TYPE(2), .SYNC_STAGES(2)
    ) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port), .out_port(out_port_a), .oe(oe_a), .irq(irq_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one write cycle; returns on the negedge after the capturing edge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        #1;
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;

        // Reset state
        #12;
        check("rst_out_port", 32'(out_port), 32'hA5);
        check("rst_oe", 32'(oe), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            check($sformatf("rst_read_addr%0d", i), readdata, 32'h0);
        end

        // Output path: direction, load, set, clear
        bus_write(3'd1, 32'hFF);
        check("dir_oe", 32'(oe), 32'hFF);
        bus_write(3'd0, 32'h0F);
        check("data_out", 32'(out_port), 32'h0F);
        bus_write(3'd4, 32'h30);
        check("outset_out", 32'(out_port), 32'h3F);
        bus_write(3'd5, 32'h03);
        check("outclear_out", 32'(out_port), 32'h3C);
        rd(3'd0);
        check("data_read_out", readdata, 32'h3C);
        bus_write(3'd6, 32'hFF);
        rd(3'd6);
        check("reserved_read", readdata, 32'h0);
        check("reserved_no_effect", 32'(out_port), 32'h3C);

        // Input path latency and rising capture on bit 3
        bus_write(3'd1, 32'h00);
        rd(3'd0);
        check("data_read_in", readdata, 32'h00);
        in_port = 8'h08;
        @(negedge clk);
        rd(3'd0);
        check("lat_e0_data", readdata, 32'h00);
        rd(3'd3);
        check("lat_e0_cap", readdata, 32'h00);
        @(negedge clk);
        rd(3'd0);
        check("lat_e1_data", readdata, 32'h08);
        rd(3'd3);
        check("lat_e1_cap", readdata, 32'h00);
        @(negedge clk);
        rd(3'd3);
        check("lat_e2_cap", readdata, 32'h08);
        check("masked_irq", 32'(irq), 32'h0);
        bus_write(3'd2, 32'h08);
        check("unmask_irq", 32'(irq), 32'h1);

        // W1C: irq holds through the write cycle, drops after the edge
        @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h08;
        chipselect = 1'b1;
        write_n    = 1'b0;
        #1;
        check("w1c_irq_before_edge", 32'(irq), 32'h1);
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        check("w1c_irq_after_edge", 32'(irq), 32'h0);
        rd(3'd3);
        check("w1c_cap", readdata, 32'h00);

        // Falling edge ignored by the rising instance
        @(negedge clk);
        in_port = 8'h00;
        repeat (3) @(negedge clk);
        rd(3'd3);
        check("fall_ignored", readdata, 32'h00);

        // Re-capture, then collide a W1C with a new rising edge
        in_port = 8'h08;
        repeat (3) @(negedge clk);
        check("recapture_irq", 32'(irq), 32'h1);
        in_port = 8'h00;
        repeat (3) @(negedge clk);
        in_port = 8'h08;
        @(negedge clk);
        @(negedge clk);
        address    = 3'd3;
        writedata  = 32'h08;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        rd(3'd3);
        check("collide_cap", readdata, 32'h08);
        check("collide_irq", 32'(irq), 32'h1);

        // Any-edge instance with mixed direction
        bus_write(3'd3, 32'hFF);
        rd(3'd3);
        check("clear_all_any", readdata_a, 32'h00);
        bus_write(3'd1, 32'hF0);
        in_port = 8'hF7;
        repeat (4) @(negedge clk);
        rd(3'd3);
        check("any_cap", readdata_a, 32'h0F);
        check("rise_cap_mixed", readdata, 32'h07);
        check("any_irq", 32'(irq_a), 32'h1);
        check("rise_irq_mixed", 32'(irq), 32'h0);
        rd(3'd0);
        check("any_data_mixed", readdata_a, 32'h37);
        bus_write(3'd0, 32'hFFFFFF00);
        check("upper_wd_ignored", 32'(out_port_a), 32'h00);
        rd(3'd0);
        check("upper_rd_zero", readdata_a, 32'h07);

        // Asynchronous reset mid-operation
        bus_write(3'd0, 32'h3C);
        rd(3'd3);
        check("pre_rst_cap", readdata_a, 32'h0F);
        check("pre_rst_irq", 32'(irq_a), 32'h1);
        check("pre_rst_out", 32'(out_port_a), 32'h3C);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_out_port", 32'(out_port_a), 32'hA5);
        check("arst_oe", 32'(oe_a), 32'h00);
        check("arst_irq", 32'(irq_a), 32'h0);
        check("arst_cap", readdata_a, 32'h00);
        rd(3'd2);
        check("arst_mask", readdata_a, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
